// File: rtl/sram_1r1w.sv
// sram_1r1w: word-addressed register-array RAM with combinational read ports
// and one clocked write port. Parameters select width, depth, one or two read
// ports and whether the write port exists at all (read-only memories are
// filled by simulation preload through the Register array).
module sram_1r1w #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 8192,
  parameter int ADDR_WIDTH = 13,
  parameter int NUM_READ   = 1,
  parameter int HAS_WRITE  = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] WriteAddress,
  input  logic [WIDTH-1:0]      WriteBus,
  input  logic [ADDR_WIDTH-1:0] ReadAddress,
  output logic [WIDTH-1:0]      ReadBus,
  input  logic [ADDR_WIDTH-1:0] ReadAddress2,
  output logic [WIDTH-1:0]      ReadBus2
);

  // Array index width; the address may be wider than needed when DEPTH is
  // smaller than 2**ADDR_WIDTH, and the extra bits only feed the range check.
  localparam int INDEX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

  // Storage, kept at this name so benches can preload and inspect it.
  logic [WIDTH-1:0] Register [0:DEPTH-1];

  // True when an address points at a real word.
  function automatic logic inRange(input logic [ADDR_WIDTH-1:0] addr);
    return {1'b0, addr} < DEPTH_LIMIT;
  endfunction

  generate
    if (HAS_WRITE != 0) begin : gWrite
      // Clocked write. Reset never clears the array; it only blocks writes, so
      // checking its level at the edge gives the same effect as an async
      // reset: any edge that sees reset low writes nothing.
      always @(posedge clock) begin
        if (reset && WE && inRange(WriteAddress)) begin
          Register[WriteAddress[INDEX_WIDTH-1:0]] <= WriteBus;
        end
      end
    end else begin : gNoWrite
      // Read-only memory: the write-side inputs are intentionally dropped.
      logic unusedWritePort;
      assign unusedWritePort = ^{clock, reset, WE, WriteAddress, WriteBus};
    end
  endgenerate

  // Port 1 reads straight from the array; out-of-range addresses return zero.
  assign ReadBus = inRange(ReadAddress) ? Register[ReadAddress[INDEX_WIDTH-1:0]]
                                        : '0;

  generate
    if (NUM_READ >= 2) begin : gRead2
      // Second independent read port, same rules as port 1.
      assign ReadBus2 = inRange(ReadAddress2) ? Register[ReadAddress2[INDEX_WIDTH-1:0]]
                                              : '0;
    end else begin : gNoRead2
      // Single-port configuration: port 2 reads as constant zero.
      logic unusedReadAddress2;
      assign unusedReadAddress2 = ^ReadAddress2;
      assign ReadBus2 = '0;
    end
  endgenerate

endmodule

// File: tb/tb_sram_1r1w.sv
// tb_sram_1r1w: checks sram_1r1w in four configurations -- default 16x8192,
// 128-bit dual-read, read-only, and a 4096-deep memory with a 13-bit address
// used for out-of-range and randomized traffic against an array model.
module tb_sram_1r1w;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Default configuration
  logic        reset0, we0;
  logic [12:0] wa0, ra0, ra0b;
  logic [15:0] wd0, rb0, rb0b;

  // 128-bit, two read ports, small depth
  logic         reset2, we2;
  logic [3:0]   wa2, ra2, ra2b;
  logic [127:0] wd2, rb2, rb2b;

  // Read-only
  logic        reset3, we3;
  logic [3:0]  wa3, ra3, ra3b;
  logic [15:0] wd3, rb3, rb3b;

  // 4096 words behind a 13-bit address
  logic        reset4, we4;
  logic [12:0] wa4, ra4, ra4b;
  logic [15:0] wd4, rb4, rb4b;

  sram_1r1w dut0 (
    .clock(clock), .reset(reset0), .WE(we0), .WriteAddress(wa0), .WriteBus(wd0),
    .ReadAddress(ra0), .ReadBus(rb0), .ReadAddress2(ra0b), .ReadBus2(rb0b));

  sram_1r1w #(.WIDTH(128), .DEPTH(16), .ADDR_WIDTH(4), .NUM_READ(2), .HAS_WRITE(1)) dut2 (
    .clock(clock), .reset(reset2), .WE(we2), .WriteAddress(wa2), .WriteBus(wd2),
    .ReadAddress(ra2), .ReadBus(rb2), .ReadAddress2(ra2b), .ReadBus2(rb2b));

  sram_1r1w #(.WIDTH(16), .DEPTH(16), .ADDR_WIDTH(4), .NUM_READ(1), .HAS_WRITE(0)) dut3 (
    .clock(clock), .reset(reset3), .WE(we3), .WriteAddress(wa3), .WriteBus(wd3),
    .ReadAddress(ra3), .ReadBus(rb3), .ReadAddress2(ra3b), .ReadBus2(rb3b));

  sram_1r1w #(.WIDTH(16), .DEPTH(4096), .ADDR_WIDTH(13), .NUM_READ(1), .HAS_WRITE(1)) dut4 (
    .clock(clock), .reset(reset4), .WE(we4), .WriteAddress(wa4), .WriteBus(wd4),
    .ReadAddress(ra4), .ReadBus(rb4), .ReadAddress2(ra4b), .ReadBus2(rb4b));

  typedef struct {
    logic        rstn;
    logic        we;
    logic [12:0] waddr;
    logic [15:0] wdata;
    logic [12:0] raddr;
    logic [15:0] expPre;
    logic [15:0] expPost;
  } vecT;

  vecT vecs [8];

  // Reference contents of dut4: written whenever an edge sees reset high,
  // WE high and an address below 4096.
  logic [15:0] model4 [0:4095];

  function automatic logic [15:0] modelRead(input logic [12:0] addr);
    return (addr < 13'd4096) ? model4[addr[11:0]] : 16'h0000;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // One table row on dut0: drive, check old data before the edge, new after.
  task automatic applyStimulus(input vecT v, input int idx);
    @(negedge clock);
    reset0 = v.rstn;
    we0    = v.we;
    wa0    = v.waddr;
    wd0    = v.wdata;
    ra0    = v.raddr;
    #1;
    checkOutput($sformatf("vec%0d_pre", idx), {112'd0, rb0}, {112'd0, v.expPre});
    @(posedge clock);
    #1;
    checkOutput($sformatf("vec%0d_post", idx), {112'd0, rb0}, {112'd0, v.expPost});
  endtask

  function automatic logic [12:0] pickAddr();
    case ($urandom_range(0, 3))
      0:       return 13'($urandom_range(0, 15));
      1:       return 13'($urandom_range(4090, 4101));
      2:       return 13'd5000;
      default: return 13'($urandom);
    endcase
  endfunction

  initial begin
    // Preload at time 0, before any clock edge.
    for (int i = 0; i < 8192; i++) dut0.Register[i] <= 16'h0000;
    dut0.Register[5] <= 16'h1234;
    dut3.Register[0] <= 16'h5A5A;
    for (int i = 0; i < 4096; i++) begin
      dut4.Register[i] <= 16'h0000;
      model4[i] = 16'h0000;
    end

    reset0 = 1'b0; we0 = 1'b0; wa0 = '0; wd0 = '0; ra0 = 13'd5; ra0b = '0;
    reset2 = 1'b0; we2 = 1'b0; wa2 = '0; wd2 = '0; ra2 = '0; ra2b = '0;
    reset3 = 1'b1; we3 = 1'b1; wa3 = '0; wd3 = 16'hFFFF; ra3 = '0; ra3b = '0;
    reset4 = 1'b0; we4 = 1'b0; wa4 = '0; wd4 = '0; ra4 = '0; ra4b = '0;

    vecs[0] = '{1'b1, 1'b1, 13'd100,  16'hFFFF, 13'd100,  16'h0000, 16'hFFFF};
    vecs[1] = '{1'b0, 1'b1, 13'd7,    16'hBEEF, 13'd7,    16'h0000, 16'h0000};
    vecs[2] = '{1'b0, 1'b0, 13'd7,    16'hBEEF, 13'd5,    16'h1234, 16'h1234};
    vecs[3] = '{1'b1, 1'b1, 13'd8191, 16'hAAAA, 13'd8191, 16'h0000, 16'hAAAA};
    vecs[4] = '{1'b1, 1'b0, 13'd8191, 16'h5555, 13'd8191, 16'hAAAA, 16'hAAAA};
    vecs[5] = '{1'b1, 1'b1, 13'd100,  16'h0001, 13'd100,  16'hFFFF, 16'h0001};
    vecs[6] = '{1'b1, 1'b1, 13'd100,  16'h0002, 13'd100,  16'h0001, 16'h0002};
    vecs[7] = '{1'b1, 1'b1, 13'd0,    16'hC0DE, 13'd0,    16'h0000, 16'hC0DE};

    #1;
    checkOutput("preload_t0", {112'd0, rb0}, {112'd0, 16'h1234});
    checkOutput("port2_tied_zero", {112'd0, rb0b}, 128'd0);

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

    // Reset dropped mid-cycle blocks the next edge; release lets the write in.
    @(negedge clock);
    reset0 = 1'b1; we0 = 1'b1; wa0 = 13'd9; wd0 = 16'h1111; ra0 = 13'd9;
    #2 reset0 = 1'b0;
    @(posedge clock); #1;
    checkOutput("async_reset_blocks", {112'd0, rb0}, 128'd0);
    @(negedge clock);
    reset0 = 1'b1;
    @(posedge clock); #1;
    checkOutput("reset_release_write", {112'd0, rb0}, {112'd0, 16'h1111});
    @(negedge clock);
    we0 = 1'b0; ra0 = 13'd5;
    #1;
    checkOutput("preload_survives_reset", {112'd0, rb0}, {112'd0, 16'h1234});

    // Dual read ports on the 128-bit memory.
    @(negedge clock);
    reset2 = 1'b1; we2 = 1'b1; wa2 = 4'd3; wd2 = 128'h1;
    @(negedge clock);
    wa2 = 4'd4; wd2 = 128'h2;
    @(negedge clock);
    we2 = 1'b0; ra2 = 4'd3; ra2b = 4'd4;
    #1;
    checkOutput("dual_port1", rb2, 128'h1);
    checkOutput("dual_port2", rb2b, 128'h2);
    ra2b = 4'd3;
    #1;
    checkOutput("dual_same_p1", rb2, 128'h1);
    checkOutput("dual_same_p2", rb2b, 128'h1);

    // Read-only memory has seen several edges with WE high at address 0.
    checkOutput("readonly_kept", {112'd0, rb3}, {112'd0, 16'h5A5A});

    // Out-of-range write on the 4096-deep memory must not alias onto 904.
    @(negedge clock);
    reset4 = 1'b1; we4 = 1'b1; wa4 = 13'd5000; wd4 = 16'hFFFF; ra4 = 13'd5000;
    @(posedge clock); #1;
    checkOutput("oor_read_zero", {112'd0, rb4}, 128'd0);
    @(negedge clock);
    we4 = 1'b0; ra4 = 13'd904;
    #1;
    checkOutput("oor_no_alias", {112'd0, rb4}, 128'd0);
    checkOutput("oor_port2_zero", {112'd0, rb4b}, 128'd0);

    // Randomized traffic on dut4 against the array model.
    for (int n = 0; n < 300; n++) begin
      @(negedge clock);
      reset4 = ($urandom_range(0, 9) != 0);
      we4    = ($urandom_range(0, 3) != 0);
      wa4    = pickAddr();
      wd4    = 16'($urandom);
      ra4    = ($urandom_range(0, 1) == 0) ? wa4 : pickAddr();
      #1;
      checkOutput($sformatf("rnd%0d_pre@%0d", n, ra4), {112'd0, rb4},
                  {112'd0, modelRead(ra4)});
      @(posedge clock); #1;
      if (reset4 && we4 && (wa4 < 13'd4096)) model4[wa4[11:0]] = wd4;
      checkOutput($sformatf("rnd%0d_post@%0d", n, ra4), {112'd0, rb4},
                  {112'd0, modelRead(ra4)});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
